// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - multi-channel synchronised edge detector
// Per channel: sync chain, mode-masked edge pulses, retriggerable stretch, sticky flag, saturating count.
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       i_lvl,
  input  logic [2*N_CH-1:0]     i_mode,
  input  logic [N_CH-1:0]       i_clr,
  output logic [N_CH-1:0]       o_edge,
  output logic [N_CH-1:0]       o_rise,
  output logic [N_CH-1:0]       o_fall,
  output logic [N_CH-1:0]       o_sticky,
  output logic [N_CH*CNT_W-1:0] o_count
);

  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);
  localparam int SW   = $clog2(PULSE_LEN + 1);
  localparam logic [WW-1:0]    WARM_V  = WW'(WARM);
  localparam logic [SW-1:0]    PULSE_V = SW'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  prev_q, prev_d;
  logic [N_CH-1:0]                  rise_q, rise_d;
  logic [N_CH-1:0]                  fall_q, fall_d;
  logic [N_CH-1:0]                  sticky_q, sticky_d;
  logic [N_CH-1:0][SW-1:0]          stretch_q, stretch_d;
  logic [N_CH-1:0][CNT_W-1:0]       count_q, count_d;
  logic [WW-1:0]                    warm_q, warm_d;
  logic                             armed;
  logic [N_CH-1:0]                  lvl_s;
  logic [N_CH-1:0]                  qual;

  // Edges are suppressed until the sync chain and prev register hold real samples.
  assign armed  = (warm_q == WARM_V);
  assign warm_d = armed ? warm_q : warm_q + WW'(1);

  always_comb begin
    sync_d    = sync_q;
    prev_d    = prev_q;
    rise_d    = '0;
    fall_d    = '0;
    sticky_d  = sticky_q;
    stretch_d = stretch_q;
    count_d   = count_q;
    lvl_s     = '0;
    qual      = '0;
    for (int k = 0; k < N_CH; k++) begin
      lvl_s[k]  = sync_q[k][SYNC_STAGES-1];
      sync_d[k] = {sync_q[k][SYNC_STAGES-2:0], i_lvl[k]};
      prev_d[k] = lvl_s[k];
      rise_d[k] = armed & lvl_s[k] & ~prev_q[k] & i_mode[2*k];
      fall_d[k] = armed & ~lvl_s[k] & prev_q[k] & i_mode[2*k+1];
      qual[k]   = rise_d[k] | fall_d[k];

      if (qual[k]) begin
        stretch_d[k] = PULSE_V;
      end else if (stretch_q[k] != '0) begin
        stretch_d[k] = stretch_q[k] - SW'(1);
      end

      // A clear coinciding with an edge still records that edge.
      if (qual[k]) begin
        sticky_d[k] = 1'b1;
      end else if (i_clr[k]) begin
        sticky_d[k] = 1'b0;
      end

      if (i_clr[k]) begin
        count_d[k] = qual[k] ? CNT_W'(1) : '0;
      end else if (qual[k] && (count_q[k] != CNT_MAX)) begin
        count_d[k] = count_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q    <= '0;
      prev_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      sticky_q  <= '0;
      stretch_q <= '0;
      count_q   <= '0;
      warm_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      sticky_q  <= sticky_d;
      stretch_q <= stretch_d;
      count_q   <= count_d;
      warm_q    <= warm_d;
    end
  end

  always_comb begin
    o_edge = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_edge[k] = (stretch_q[k] != '0);
    end
  end

  assign o_rise   = rise_q;
  assign o_fall   = fall_q;
  assign o_sticky = sticky_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - bench for multi_edge_detector
// Two instances (short/long stretch, wide/narrow counter) against a sample-history model.
module tb_multi_edge_detector;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  lvl  = 4'hF;
  logic [7:0]  mode = 8'hFF;
  logic [3:0]  clr  = 4'h0;

  logic [3:0]  edge_a, rise_a, fall_a, sticky_a;
  logic [31:0] count_a;
  logic [3:0]  edge_b, rise_b, fall_b, sticky_b;
  logic [11:0] count_b;

  int checks = 0;
  int errors = 0;

  multi_edge_detector #(.N_CH(4), .SYNC_STAGES(2), .PULSE_LEN(1), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_lvl(lvl), .i_mode(mode), .i_clr(clr),
    .o_edge(edge_a), .o_rise(rise_a), .o_fall(fall_a), .o_sticky(sticky_a), .o_count(count_a));

  multi_edge_detector #(.N_CH(4), .SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_lvl(lvl), .i_mode(mode), .i_clr(clr),
    .o_edge(edge_b), .o_rise(rise_b), .o_fall(fall_b), .o_sticky(sticky_b), .o_count(count_b));

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: output at clock n reflects the input sampled at clock n-2 versus n-3.
  logic [3:0] hist[$];
  int         n_m = 0;
  int         last_q[4] = '{0, 0, 0, 0};
  int         cnt_a[4]  = '{0, 0, 0, 0};
  int         cnt_b[4]  = '{0, 0, 0, 0};
  logic [3:0] e_rise = 0, e_fall = 0, e_sticky = 0, e_edge_a = 0, e_edge_b = 0;
  logic       m_s, m_p, m_q;

  function automatic logic [3:0] hist_at(int idx);
    if (idx < 1 || idx > hist.size()) return 4'b0;
    return hist[idx-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      n_m = 0;
      for (int k = 0; k < 4; k++) begin
        last_q[k] = 0; cnt_a[k] = 0; cnt_b[k] = 0;
      end
      e_rise = 0; e_fall = 0; e_sticky = 0; e_edge_a = 0; e_edge_b = 0;
    end else begin
      n_m++;
      hist.push_back(lvl);
      for (int k = 0; k < 4; k++) begin
        m_s = hist_at(n_m - 2)[k];
        m_p = hist_at(n_m - 3)[k];
        e_rise[k] = (n_m > 3) && m_s && !m_p && mode[2*k];
        e_fall[k] = (n_m > 3) && !m_s && m_p && mode[2*k+1];
        m_q = e_rise[k] | e_fall[k];
        if (m_q) last_q[k] = n_m;
        if (clr[k]) begin
          cnt_a[k] = m_q ? 1 : 0;
          cnt_b[k] = m_q ? 1 : 0;
        end else if (m_q) begin
          if (cnt_a[k] < 255) cnt_a[k]++;
          if (cnt_b[k] < 7) cnt_b[k]++;
        end
        if (m_q) e_sticky[k] = 1'b1;
        else if (clr[k]) e_sticky[k] = 1'b0;
        e_edge_a[k] = (last_q[k] > 0) && (n_m - last_q[k] < 1);
        e_edge_b[k] = (last_q[k] > 0) && (n_m - last_q[k] < 4);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_rise_a", rise_a, e_rise);
    chk("m_fall_a", fall_a, e_fall);
    chk("m_edge_a", edge_a, e_edge_a);
    chk("m_sticky_a", sticky_a, e_sticky);
    chk("m_count_a", count_a, {8'(cnt_a[3]), 8'(cnt_a[2]), 8'(cnt_a[1]), 8'(cnt_a[0])});
    chk("m_rise_b", rise_b, e_rise);
    chk("m_fall_b", fall_b, e_fall);
    chk("m_edge_b", edge_b, e_edge_b);
    chk("m_sticky_b", sticky_b, e_sticky);
    chk("m_count_b", count_b, {3'(cnt_b[3]), 3'(cnt_b[2]), 3'(cnt_b[1]), 3'(cnt_b[0])});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic       lvl0;
    logic       rise0, fall0, edge0, sticky0;
    logic [7:0] cnt0;
  } vec_t;

  vec_t tbl[8];
  logic seen;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};

    // Reset with all inputs high, then warm-up must report nothing.
    repeat (3) tick();
    chk("rst_outs_a", {edge_a, rise_a, fall_a, sticky_a}, 16'h0);
    chk("rst_count_a", count_a, 32'h0);
    chk("rst_count_b", count_b, 12'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("warm_rise_edge", {rise_a, edge_a, edge_b}, 12'h0);
      chk("warm_count", {count_a, count_b}, 44'h0);
    end

    // Table: ch0 both-edge mode, fall then rise.
    for (int i = 0; i < 8; i++) begin
      lvl[0] = tbl[i].lvl0;
      tick();
      chk("tbl_rise0", rise_a[0], tbl[i].rise0);
      chk("tbl_fall0", fall_a[0], tbl[i].fall0);
      chk("tbl_edge0", edge_a[0], tbl[i].edge0);
      chk("tbl_sticky0", sticky_a[0], tbl[i].sticky0);
      chk("tbl_count0", count_a[7:0], tbl[i].cnt0);
    end

    // ch1 rise-only: toggle 1->0->1.
    mode = 8'hF7;
    seen = 1'b0;
    lvl[1] = 1'b0;
    repeat (3) begin tick(); seen |= fall_a[1] | fall_b[1]; end
    lvl[1] = 1'b1;
    repeat (4) begin tick(); seen |= fall_a[1] | fall_b[1]; end
    chk("ch1_no_fall", seen, 1'b0);
    chk("ch1_count", count_a[15:8], 8'd1);
    chk("ch1_sticky", sticky_a[1], 1'b1);

    // ch2 edges two clocks apart merge into one stretched pulse on dut_b.
    for (int i = 0; i < 12; i++) begin
      lvl[2] = (i == 2 || i == 3);
      tick();
      chk("stretch_merge", edge_b[2], (i >= 2 && i <= 9));
    end

    // ch3 rise-only: saturation on the 3-bit counter.
    mode = 8'h77;
    clr[3] = 1'b1; tick(); clr[3] = 1'b0;
    repeat (10) begin
      lvl[3] = 1'b0; tick(); tick();
      lvl[3] = 1'b1; tick(); tick();
    end
    repeat (4) tick();
    chk("sat_count_b", count_b[11:9], 3'd7);
    chk("nosat_count_a", count_a[31:24], 8'd10);
    lvl[3] = 1'b0; repeat (3) tick();
    lvl[3] = 1'b1; tick(); tick();
    clr[3] = 1'b1; tick(); clr[3] = 1'b0;
    chk("clr_edge_count_b", count_b[11:9], 3'd1);
    chk("clr_edge_count_a", count_a[31:24], 8'd1);
    chk("clr_edge_sticky", {sticky_a[3], sticky_b[3]}, 2'b11);
    clr[3] = 1'b1; tick(); clr[3] = 1'b0;
    chk("clr_only_count", {count_a[31:24], count_b[11:9]}, 11'h0);
    chk("clr_only_sticky", {sticky_a[3], sticky_b[3]}, 2'b00);

    // Reset mid-stretch with count 5, then a toggle inside warm-up.
    repeat (5) begin
      lvl[3] = 1'b0; tick(); tick();
      lvl[3] = 1'b1; tick(); tick();
    end
    tick();
    chk("pre_rst_count_b", count_b[11:9], 3'd5);
    chk("pre_rst_edge_b", edge_b[3], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_b", {edge_b, rise_b, fall_b, sticky_b, count_b}, 28'h0);
    chk("async_rst_a", {edge_a, rise_a, fall_a, sticky_a, count_a}, 48'h0);
    tick(); tick();
    rst = 1'b0;
    mode = 8'hFF;
    lvl[3] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= rise_a[3] | fall_a[3] | edge_a[3] | rise_b[3] | fall_b[3] | edge_b[3];
    end
    chk("warm_toggle_seen", seen, 1'b0);
    chk("warm_toggle_count", {count_a[31:24], count_b[11:9]}, 11'h0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(3) == 0) lvl[k] = ~lvl[k];
        clr[k] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(15) == 0) mode = 8'($urandom);
      if ($urandom_range(199) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      tick();
    end
    clr = 4'h0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
